// File: rtl/pixel_batch_scheduler.sv
// Sequences the pixel processor batch by batch across a frame and serializes each
// packed result into the scan-out FIFO. Optional overlap mode: PIXEL_SCHED_OVERLAP_EN.
module pixel_batch_scheduler #(
  parameter int NUM_PIXELS        = 8,
  parameter int PIXEL_WIDTH       = 12,
  parameter int BATCHES_PER_FRAME = 38400,
  parameter int FIFO_COUNT_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  output logic                              proc_new_frame,
  output logic                              proc_start_next_batch,
  input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] proc_result,
  input  logic                              proc_result_ready,
  input  logic [FIFO_COUNT_WIDTH-1:0]       fifo_free_count,
  output logic                              fifo_wr_en,
  output logic [PIXEL_WIDTH-1:0]            fifo_wr_data,
  output logic                              frame_done,
  output logic                              frame_overrun
);

  localparam int RES_W = NUM_PIXELS * PIXEL_WIDTH;
  localparam int CNT_W = $clog2(BATCHES_PER_FRAME + 1);
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  localparam logic [CNT_W-1:0]          BPF_CNT  = CNT_W'(BATCHES_PER_FRAME);
  localparam logic [CNT_W-1:0]          LAST_CNT = CNT_W'(BATCHES_PER_FRAME - 1);
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [FIFO_COUNT_WIDTH:0] ROOM_ONE = (FIFO_COUNT_WIDTH + 1)'(NUM_PIXELS);
`ifdef PIXEL_SCHED_OVERLAP_EN
  localparam logic [FIFO_COUNT_WIDTH:0] ROOM_TWO = (FIFO_COUNT_WIDTH + 1)'(2 * NUM_PIXELS);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_LAUNCH,
    S_WAIT_RESULT,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   batch_cnt_q, batch_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RES_W-1:0]   shadow_q, shadow_d;
  logic               first_batch_q, first_batch_d;
  logic               guard_q, guard_d;
  logic               overlap_q, overlap_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_overrun_q, frame_overrun_d;

  logic [PIXEL_WIDTH-1:0] shadow_pix [NUM_PIXELS];
  logic [CNT_W-1:0]       cnt_inc;
  logic                   has_room;

  for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
    assign shadow_pix[gi] = shadow_q[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  assign cnt_inc  = batch_cnt_q + CNT_W'(1);
  assign has_room = {1'b0, fifo_free_count} >= ROOM_ONE;

  always_comb begin
    state_d               = state_q;
    batch_cnt_d           = batch_cnt_q;
    idx_d                 = idx_q;
    shadow_d              = shadow_q;
    first_batch_d         = first_batch_q;
    guard_d               = 1'b0;
    overlap_d             = overlap_q;
    frame_done_d          = 1'b0;
    frame_overrun_d       = 1'b0;
    proc_new_frame        = 1'b0;
    proc_start_next_batch = 1'b0;
    fifo_wr_en            = 1'b0;
    fifo_wr_data          = '0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d       = S_WAIT_ROOM;
          first_batch_d = 1'b1;
          batch_cnt_d   = '0;
        end
      end
      S_WAIT_ROOM: begin
        if (has_room) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        proc_new_frame        = first_batch_q;
        proc_start_next_batch = !first_batch_q;
        first_batch_d         = 1'b0;
        guard_d               = 1'b1;
        state_d               = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        // A ready still high from the previous batch is ignored on the first cycle.
        if (!guard_q && proc_result_ready) begin
          shadow_d = proc_result;
          idx_d    = '0;
          state_d  = S_DRAIN;
`ifdef PIXEL_SCHED_OVERLAP_EN
          if (!frame_start && (batch_cnt_q < LAST_CNT) &&
              ({1'b0, fifo_free_count} >= ROOM_TWO)) begin
            proc_start_next_batch = 1'b1;
            overlap_d             = 1'b1;
          end
`endif
        end
      end
      S_DRAIN: begin
        fifo_wr_en   = 1'b1;
        fifo_wr_data = shadow_pix[idx_q];
        if (idx_q == LAST_IDX) begin
          if (cnt_inc == BPF_CNT) begin
            frame_done_d = 1'b1;
            batch_cnt_d  = '0;
            overlap_d    = 1'b0;
            state_d      = S_IDLE;
          end else begin
            batch_cnt_d = cnt_inc;
            if (overlap_q) begin
              overlap_d = 1'b0;
              guard_d   = 1'b1;
              state_d   = S_WAIT_RESULT;
            end else begin
              state_d = S_WAIT_ROOM;
            end
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame arriving mid-frame abandons whatever batch is in progress.
    if (frame_start && (state_q != S_IDLE)) begin
      frame_overrun_d = 1'b1;
      frame_done_d    = 1'b0;
      batch_cnt_d     = '0;
      first_batch_d   = 1'b1;
      overlap_d       = 1'b0;
      guard_d         = 1'b0;
      idx_d           = '0;
      state_d         = S_WAIT_ROOM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      batch_cnt_q     <= '0;
      idx_q           <= '0;
      shadow_q        <= '0;
      first_batch_q   <= 1'b0;
      guard_q         <= 1'b0;
      overlap_q       <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      batch_cnt_q     <= batch_cnt_d;
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      first_batch_q   <= first_batch_d;
      guard_q         <= guard_d;
      overlap_q       <= overlap_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_pixel_batch_scheduler.sv
// Directed bench for pixel_batch_scheduler with a small processor model (4 batches/frame).
module tb_pixel_batch_scheduler;

  localparam int NP  = 8;
  localparam int PW  = 12;
  localparam int BPF = 4;
  localparam int FCW = 10;
  localparam int LAT = 16;

`ifdef PIXEL_SCHED_OVERLAP_EN
  localparam int EXP_FRAME_LEN = 79;
  localparam int EXP_COIN      = 3;
  localparam int EXP_NX_OVR    = 6;
`else
  localparam int EXP_FRAME_LEN = 109;
  localparam int EXP_COIN      = 0;
  localparam int EXP_NX_OVR    = 5;
`endif

  logic             clk;
  logic             reset;
  logic             frame_start;
  logic             proc_new_frame;
  logic             proc_start_next_batch;
  logic [NP*PW-1:0] proc_result;
  logic             proc_result_ready;
  logic [FCW-1:0]   fifo_free_count;
  logic             fifo_wr_en;
  logic [PW-1:0]    fifo_wr_data;
  logic             frame_done;
  logic             frame_overrun;

  pixel_batch_scheduler #(
    .NUM_PIXELS(NP), .PIXEL_WIDTH(PW), .BATCHES_PER_FRAME(BPF), .FIFO_COUNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .proc_new_frame(proc_new_frame), .proc_start_next_batch(proc_start_next_batch),
    .proc_result(proc_result), .proc_result_ready(proc_result_ready),
    .fifo_free_count(fifo_free_count), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NP*PW-1:0] pack(input logic [PW-1:0] base);
    logic [NP*PW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*PW +: PW] = base + PW'(i);
    return r;
  endfunction

  // Processor model: result ready LAT+1 cycles after a command, held until the next one.
  logic             m_ready;
  logic [7:0]       m_cd;
  logic [PW-1:0]    m_base;
  logic [NP*PW-1:0] m_result;
  logic             man_mode;
  logic             man_ready;
  logic [NP*PW-1:0] man_result;

  always @(posedge clk) begin
    if (reset) begin
      m_ready  <= 1'b0;
      m_cd     <= '0;
      m_base   <= '0;
      m_result <= '0;
    end else if (proc_new_frame || proc_start_next_batch) begin
      m_ready <= 1'b0;
      m_cd    <= 8'(LAT);
      m_base  <= proc_new_frame ? '0 : m_base + PW'(8);
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 8'd1;
      if (m_cd == 8'd1) begin
        m_ready  <= 1'b1;
        m_result <= pack(m_base);
      end
    end
  end

  assign proc_result_ready = man_mode ? man_ready : m_ready;
  assign proc_result       = man_mode ? man_result : m_result;

  // Output monitor, sampled on the falling edge.
  int         cyc, wr_cnt, nf_cnt, nx_cnt, done_cnt, ovr_cnt, coin_cnt, fs_cyc, done_cyc;
  logic       prev_wr, prev_nx;
  logic [PW-1:0] wr_log [256];

  always @(negedge clk) begin
    if (reset) begin
      cyc <= 0; wr_cnt <= 0; nf_cnt <= 0; nx_cnt <= 0; done_cnt <= 0;
      ovr_cnt <= 0; coin_cnt <= 0; fs_cyc <= 0; done_cyc <= 0;
      prev_wr <= 1'b0; prev_nx <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (fifo_wr_en) begin
        wr_log[wr_cnt[7:0]] <= fifo_wr_data;
        wr_cnt <= wr_cnt + 1;
      end
      if (proc_new_frame) nf_cnt <= nf_cnt + 1;
      if (proc_start_next_batch) nx_cnt <= nx_cnt + 1;
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (frame_overrun) ovr_cnt <= ovr_cnt + 1;
      if (frame_start) fs_cyc <= cyc;
      if (fifo_wr_en && !prev_wr && prev_nx) coin_cnt <= coin_cnt + 1;
      prev_wr <= fifo_wr_en;
      prev_nx <= proc_start_next_batch;
    end
  end

  int total;
  int bad;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [FCW-1:0] free;
    int             exp_lat;
  } room_vec_t;

  room_vec_t room_tbl [6];

  initial begin
    int lat;
    int pre;
    int ok;
    int n;

    room_tbl[0] = '{free: 10'd0,    exp_lat: 0};
    room_tbl[1] = '{free: 10'd7,    exp_lat: 0};
    room_tbl[2] = '{free: 10'd8,    exp_lat: 2};
    room_tbl[3] = '{free: 10'd9,    exp_lat: 2};
    room_tbl[4] = '{free: 10'd64,   exp_lat: 2};
    room_tbl[5] = '{free: 10'd1023, exp_lat: 2};

    total = 0; bad = 0;
    reset = 1'b1; frame_start = 1'b0; fifo_free_count = 10'd64;
    man_mode = 1'b0; man_ready = 1'b0; man_result = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_new_frame", int'(proc_new_frame), 0);
    chk("rst_next_batch", int'(proc_start_next_batch), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_wr_data", int'(fifo_wr_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(frame_overrun), 0);

    // Launch latency versus free space.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      fifo_free_count = room_tbl[r].free;
      frame_start     = 1'b1;
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
        tick();
        frame_start = 1'b0;
        if (proc_new_frame && lat == 0) lat = k;
      end
      $display("room row %0d: free=%0d launch_latency=%0d", r, room_tbl[r].free, lat);
      chk("room_latency", lat, room_tbl[r].exp_lat);
    end

    // Seven entries for 50 cycles, then eight: launch exactly one cycle later.
    do_reset();
    fifo_free_count = 10'd7;
    frame_start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      frame_start = 1'b0;
    end
    chk("hold7_no_launch", nf_cnt, 0);
    fifo_free_count = 10'd8;
    chk("hold7_same_cycle", int'(proc_new_frame), 0);
    tick();
    chk("hold7_launch_next", int'(proc_new_frame), 1);
    $display("hold at 7 then 8: new_frame=%0d", proc_new_frame);

    // Full serial/overlap frame.
    do_reset();
    fifo_free_count = 10'd64;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(400, "frame");
    for (int k = 0; k < 20; k++) tick();
    chk("frame_new_frame_cnt", nf_cnt, 1);
    chk("frame_next_batch_cnt", nx_cnt, 3);
    chk("frame_writes", wr_cnt, 32);
    ok = 1;
    for (int i = 0; i < 32; i++) if (wr_log[i] != PW'(i)) ok = 0;
    chk("frame_pixel_order", ok, 1);
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_length", done_cyc - fs_cyc, EXP_FRAME_LEN);
    chk("frame_overlap_coincide", coin_cnt, EXP_COIN);
    $display("frame: writes=%0d length=%0d overlaps=%0d", wr_cnt, done_cyc - fs_cyc, coin_cnt);

    // Overrun during drain of batch 2, pixel index 3.
    do_reset();
    fifo_free_count = 10'd64;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!(fifo_wr_en && fifo_wr_data == 12'h013) && n < 300) begin
      tick();
      n++;
    end
    chk("ovr_found_pixel3", int'(fifo_wr_en && fifo_wr_data == 12'h013), 1);
    pre = wr_cnt + 1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_pulse", int'(frame_overrun), 1);
    chk("ovr_writes_stop", int'(fifo_wr_en), 0);
    wait_done(400, "ovr");
    for (int k = 0; k < 10; k++) tick();
    chk("ovr_pulse_cnt", ovr_cnt, 1);
    chk("ovr_pre_writes", pre, 20);
    chk("ovr_total_writes", wr_cnt, pre + 32);
    ok = 1;
    for (int i = 0; i < 32; i++) if (wr_log[pre + i] != PW'(i)) ok = 0;
    chk("ovr_restart_pixels", ok, 1);
    chk("ovr_new_frame_cnt", nf_cnt, 2);
    chk("ovr_next_batch_cnt", nx_cnt, EXP_NX_OVR);
    $display("overrun: pre_writes=%0d total_writes=%0d", pre, wr_cnt);

    // Reset together with frame_start while waiting for a result.
    do_reset();
    fifo_free_count = 10'd64;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!proc_new_frame && n < 20) begin
      tick();
      n++;
    end
    chk("rstmid_launch_seen", int'(proc_new_frame), 1);
    tick(); tick();
    reset = 1'b1;
    frame_start = 1'b1;
    tick();
    reset = 1'b0;
    frame_start = 1'b0;
    chk("rstmid_wr_en", int'(fifo_wr_en), 0);
    chk("rstmid_cmds", int'(proc_new_frame | proc_start_next_batch), 0);
    chk("rstmid_overrun", int'(frame_overrun), 0);
    chk("rstmid_done", int'(frame_done), 0);
    for (int k = 0; k < 30; k++) tick();
    chk("rstmid_idle_no_launch", nf_cnt, 0);
    chk("rstmid_no_overrun", ovr_cnt, 0);
    $display("reset mid-wait: launches=%0d overruns=%0d", nf_cnt, ovr_cnt);

    // Stale ready during the first WAIT_RESULT cycle must be ignored.
    do_reset();
    man_mode = 1'b1;
    man_ready = 1'b0;
    fifo_free_count = 10'd64;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!proc_new_frame && n < 20) begin
      tick();
      n++;
    end
    man_result = pack(12'h100);
    man_ready  = 1'b1;
    tick();
    tick();
    man_ready = 1'b0;
    chk("stale_not_captured", int'(fifo_wr_en), 0);
    for (int k = 0; k < 3; k++) tick();
    chk("stale_no_writes", wr_cnt, 0);
    man_result = pack(12'h200);
    man_ready  = 1'b1;
    tick();
    man_ready = 1'b0;
    chk("stale_capture_wr_en", int'(fifo_wr_en), 1);
    chk("stale_capture_data", int'(fifo_wr_data), 'h200);
    for (int k = 0; k < 10; k++) tick();
    ok = (wr_cnt == 8) ? 1 : 0;
    for (int i = 0; i < 8; i++) if (wr_log[i] != 12'h200 + PW'(i)) ok = 0;
    chk("stale_batch_pixels", ok, 1);
    $display("stale ready: writes=%0d", wr_cnt);
    man_mode = 1'b0;
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
